// File: rtl/control_escritura_rtc_pkg.sv
// ---------------------------------------------------------------------------
// control_escritura_rtc_pkg
// Shared definitions for the RTC write sequencer: FSM state encoding,
// default timing/sequence constants and counter widths.
// ---------------------------------------------------------------------------
package control_escritura_rtc_pkg;

    // Default bus timing (in clk cycles) and number of registers per sequence
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 4;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_N_REG   = 9;

    // Width of the phase down-counter and of the register index
    localparam int FASE_W   = 16;
    localparam int CUENTA_W = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR_SETUP = 3'd1,
        ADDR_WR    = 3'd2,
        ADDR_HOLD  = 3'd3,
        DATA_SETUP = 3'd4,
        DATA_WR    = 3'd5,
        DATA_HOLD  = 3'd6,
        DONE       = 3'd7
    } estado_t;

    // True for the states in which the RTC bus cycle is active (cs_n low)
    function automatic logic en_ciclo_bus(input estado_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    // True for the data half of a register write
    function automatic logic es_fase_dato(input estado_t s);
        return (s == DATA_SETUP) || (s == DATA_WR) || (s == DATA_HOLD);
    endfunction

endpackage

// File: rtl/control_escritura_rtc_if.sv
// ---------------------------------------------------------------------------
// control_escritura_rtc_if
// Groups the request inputs and the RTC bus/status outputs of the write
// sequencer.
//   start, prog        : request a sequence / initialization mode
//   cuenta             : register index for the write decoder
//   a_d                : 0 address phase, 1 data phase
//   cs_n, wr_n, rd_n   : RTC bus strobes (active low)
//   deco_en_n          : write-decoder enable (active low)
//   prog_q             : prog captured at start
//   busy, done         : sequence status
// Modports: master drives the requests (controller side / bench),
//           slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface control_escritura_rtc_if;
    import control_escritura_rtc_pkg::*;

    logic                start;
    logic                prog;
    logic [CUENTA_W-1:0] cuenta;
    logic                a_d;
    logic                cs_n;
    logic                wr_n;
    logic                rd_n;
    logic                deco_en_n;
    logic                prog_q;
    logic                busy;
    logic                done;

    modport master (
        output start, prog,
        input  cuenta, a_d, cs_n, wr_n, rd_n, deco_en_n, prog_q, busy, done
    );

    modport slave (
        input  start, prog,
        output cuenta, a_d, cs_n, wr_n, rd_n, deco_en_n, prog_q, busy, done
    );

endinterface

// File: rtl/control_escritura_rtc_temporizador_fase.sv
// ---------------------------------------------------------------------------
// temporizador_fase
// Loadable down-counter timing one FSM phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   carga      : load valor (takes priority over counting)
//   valor      : phase length minus one
//   fin        : high while the count is zero (last cycle of the phase)
// ---------------------------------------------------------------------------
module temporizador_fase
    import control_escritura_rtc_pkg::*;
#(
    parameter int W = FASE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carga,
    input  logic [W-1:0] valor,
    output logic         fin
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (carga) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign fin = (cnt == '0);

endmodule

// File: rtl/control_escritura_rtc.sv
// ---------------------------------------------------------------------------
// control_escritura_rtc
// Drives an RTC parallel bus through a full write sequence: for each of
// N_REG registers an address cycle then a data cycle, each made of
// setup / write-strobe / hold phases of T_SETUP / T_PULSE / T_HOLD clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of control_escritura_rtc_if (start/prog in,
//                cuenta, a_d, cs_n, wr_n, rd_n, deco_en_n, prog_q,
//                busy, done out)
// All strobes are decoded from the state register, so an asynchronous
// reset releases wr_n/cs_n immediately.
// ---------------------------------------------------------------------------
module control_escritura_rtc
    import control_escritura_rtc_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int N_REG   = DEF_N_REG
) (
    input  logic                    clk,
    input  logic                    rst_n,
    control_escritura_rtc_if.slave  bus
);

    estado_t             estado;
    estado_t             estado_sig;
    logic                fin_fase;
    logic                carga_fase;
    logic [FASE_W-1:0]   valor_fase;
    logic [CUENTA_W-1:0] cuenta_q;
    logic                prog_r;
    logic                a_d_q;
    logic                a_d_o;
    logic                ultimo_reg;
    logic                arranque;

    assign ultimo_reg = (cuenta_q == CUENTA_W'(N_REG - 1));
    assign arranque   = (estado == IDLE) && bus.start;

    // -----------------------------------------------------------------
    // Phase timer: reloaded on every state change with the length of
    // the state being entered.
    // -----------------------------------------------------------------
    always_comb begin
        carga_fase = (estado_sig != estado);
        valor_fase = '0;
        case (estado_sig)
            ADDR_SETUP, DATA_SETUP: valor_fase = FASE_W'(T_SETUP - 1);
            ADDR_WR,    DATA_WR:    valor_fase = FASE_W'(T_PULSE - 1);
            ADDR_HOLD,  DATA_HOLD:  valor_fase = FASE_W'(T_HOLD - 1);
            default:                valor_fase = '0;
        endcase
    end

    temporizador_fase #(
        .W (FASE_W)
    ) u_temporizador_fase (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (carga_fase),
        .valor (valor_fase),
        .fin   (fin_fase)
    );

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:       if (bus.start) estado_sig = ADDR_SETUP;
            ADDR_SETUP: if (fin_fase)  estado_sig = ADDR_WR;
            ADDR_WR:    if (fin_fase)  estado_sig = ADDR_HOLD;
            ADDR_HOLD:  if (fin_fase)  estado_sig = DATA_SETUP;
            DATA_SETUP: if (fin_fase)  estado_sig = DATA_WR;
            DATA_WR:    if (fin_fase)  estado_sig = DATA_HOLD;
            DATA_HOLD:  if (fin_fase)  estado_sig = ultimo_reg ? DONE : ADDR_SETUP;
            DONE:                      estado_sig = IDLE;
            default:                   estado_sig = IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // Sequence registers: register index, captured prog, and the last
    // a_d value so it can be held while idle.
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
            prog_r   <= 1'b0;
            a_d_q    <= 1'b0;
        end else begin
            a_d_q <= a_d_o;
            if (arranque) begin
                cuenta_q <= '0;
                prog_r   <= bus.prog;
            end else if ((estado == DATA_HOLD) && fin_fase && !ultimo_reg) begin
                cuenta_q <= cuenta_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------
    always_comb begin
        if (en_ciclo_bus(estado)) begin
            a_d_o = es_fase_dato(estado);
        end else begin
            a_d_o = a_d_q;
        end
    end

    always_comb begin
        bus.cuenta    = cuenta_q;
        bus.a_d       = a_d_o;
        bus.cs_n      = !en_ciclo_bus(estado);
        bus.wr_n      = !((estado == ADDR_WR) || (estado == DATA_WR));
        bus.rd_n      = 1'b1;
        bus.busy      = (estado != IDLE);
        bus.deco_en_n = (estado == IDLE);
        bus.done      = (estado == DONE);
        bus.prog_q    = prog_r;
    end

endmodule

// File: tb/tb_control_escritura_rtc.sv
// ---------------------------------------------------------------------------
// tb_control_escritura_rtc
// Directed bench for control_escritura_rtc: a default-parameter instance
// (9 registers) and a single-register instance (N_REG=1) share clk/rst_n.
// Cycle n counts rising edges after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_control_escritura_rtc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    control_escritura_rtc_if bus_a();
    control_escritura_rtc_if bus_b();

    control_escritura_rtc u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    control_escritura_rtc #(
        .T_SETUP (2),
        .T_PULSE (4),
        .T_HOLD  (2),
        .N_REG   (1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs of instance A at their reset values
    task automatic chk_reset_a(input string pfx);
        chk({pfx, "_cuenta"},    32'(bus_a.cuenta),    0);
        chk({pfx, "_a_d"},       32'(bus_a.a_d),       0);
        chk({pfx, "_cs_n"},      32'(bus_a.cs_n),      1);
        chk({pfx, "_wr_n"},      32'(bus_a.wr_n),      1);
        chk({pfx, "_rd_n"},      32'(bus_a.rd_n),      1);
        chk({pfx, "_deco_en_n"}, 32'(bus_a.deco_en_n), 1);
        chk({pfx, "_prog_q"},    32'(bus_a.prog_q),    0);
        chk({pfx, "_busy"},      32'(bus_a.busy),      0);
        chk({pfx, "_done"},      32'(bus_a.done),      0);
    endtask

    // Expected timeline of a default sequence: 16-cycle register slots,
    // wr_n low in slot cycles 3-6 and 11-14, done at 145, idle after.
    task automatic chk_cycle_a(input int n);
        int p;
        int e_cuenta, e_ad, e_wr, e_cs, e_busy, e_done;
        if (n <= 144) begin
            p        = (n - 1) % 16;
            e_cuenta = (n - 1) / 16;
            e_ad     = (p >= 8) ? 1 : 0;
            e_wr     = ((p >= 2 && p <= 5) || (p >= 10 && p <= 13)) ? 0 : 1;
            e_cs     = 0;
            e_busy   = 1;
            e_done   = 0;
        end else begin
            e_cuenta = 8;
            e_ad     = 1;
            e_wr     = 1;
            e_cs     = 1;
            e_busy   = (n == 145) ? 1 : 0;
            e_done   = (n == 145) ? 1 : 0;
        end
        chk($sformatf("a_cuenta@%0d", n), 32'(bus_a.cuenta),    32'(e_cuenta));
        chk($sformatf("a_a_d@%0d", n),    32'(bus_a.a_d),       32'(e_ad));
        chk($sformatf("a_wr_n@%0d", n),   32'(bus_a.wr_n),      32'(e_wr));
        chk($sformatf("a_cs_n@%0d", n),   32'(bus_a.cs_n),      32'(e_cs));
        chk($sformatf("a_busy@%0d", n),   32'(bus_a.busy),      32'(e_busy));
        chk($sformatf("a_deco@%0d", n),   32'(bus_a.deco_en_n), 32'(1 - e_busy));
        chk($sformatf("a_done@%0d", n),   32'(bus_a.done),      32'(e_done));
        chk($sformatf("a_rd_n@%0d", n),   32'(bus_a.rd_n),      1);
    endtask

    // Single register: a_d 0 for 8 cycles then 1 for 8, cs_n low 1..16
    task automatic chk_cycle_b(input int n);
        int e_ad, e_wr, e_cs, e_busy, e_done;
        e_ad   = (n >= 9) ? 1 : 0;
        e_wr   = ((n >= 3 && n <= 6) || (n >= 11 && n <= 14)) ? 0 : 1;
        e_cs   = (n <= 16) ? 0 : 1;
        e_busy = (n <= 17) ? 1 : 0;
        e_done = (n == 17) ? 1 : 0;
        chk($sformatf("b_a_d@%0d", n),    32'(bus_b.a_d),    32'(e_ad));
        chk($sformatf("b_wr_n@%0d", n),   32'(bus_b.wr_n),   32'(e_wr));
        chk($sformatf("b_cs_n@%0d", n),   32'(bus_b.cs_n),   32'(e_cs));
        chk($sformatf("b_busy@%0d", n),   32'(bus_b.busy),   32'(e_busy));
        chk($sformatf("b_done@%0d", n),   32'(bus_b.done),   32'(e_done));
        chk($sformatf("b_cuenta@%0d", n), 32'(bus_b.cuenta), 0);
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_a.prog  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.prog  = 1'b0;

        // Reset state
        #12;
        chk_reset_a("rst");
        chk("rst_b_busy", 32'(bus_b.busy), 0);

        // Release and request on the same cycle: first edge must accept it
        step();
        rst_n       = 1'b1;
        bus_a.start = 1'b1;
        bus_a.prog  = 1'b1;
        bus_b.start = 1'b1;

        // Full sequence with stray starts at 5/50/143 and prog toggling
        for (int n = 1; n <= 160; n++) begin
            step();
            bus_b.start = 1'b0;
            bus_a.start = (n == 5 || n == 50 || n == 143) ? 1'b1 : 1'b0;
            bus_a.prog  = n[0];
            chk_cycle_a(n);
            chk_cycle_b(n);
            chk($sformatf("a_prog_q@%0d", n), 32'(bus_a.prog_q), 1);
        end

        // Asynchronous reset in the middle of a sequence
        bus_a.start = 1'b1;
        bus_a.prog  = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            step();
            bus_a.start = 1'b0;
        end
        chk("mid_wr_n_before", 32'(bus_a.wr_n),   0);
        chk("mid_cuenta_before", 32'(bus_a.cuenta), 4);
        chk("mid_prog_q_before", 32'(bus_a.prog_q), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_a("async");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("inrst_done%0d", i), 32'(bus_a.done), 0);
            chk($sformatf("inrst_busy%0d", i), 32'(bus_a.busy), 0);
        end
        rst_n       = 1'b1;
        bus_a.start = 1'b1;
        bus_a.prog  = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            step();
            bus_a.start = 1'b0;
            chk_cycle_a(n);
        end

        // Start held high: back-to-back sequences with one idle cycle
        bus_a.start = 1'b1;
        for (int n = 1; n <= 146; n++) begin
            step();
            chk_cycle_a(n);
        end
        step();
        chk("b2b_busy", 32'(bus_a.busy),   1);
        chk("b2b_cuenta", 32'(bus_a.cuenta), 0);
        chk("b2b_a_d", 32'(bus_a.a_d),    0);
        chk("b2b_cs_n", 32'(bus_a.cs_n),   0);
        bus_a.start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
